// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner: walks an active-low column across the matrix, samples
// the synchronised active-low rows once per column dwell, debounces single-key
// presses and releases, and rejects samples showing more than one row low.
module keypad_scan_debounce #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned DEBOUNCE_COUNT = 3,
  localparam int unsigned KEY_W         = $clog2(ROWS*COLS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ROWS-1:0]      row,
  output logic [COLS-1:0]      col,
  output logic [KEY_W-1:0]     keycode,
  output logic                 key_valid,
  output logic                 key_held,
  output logic                 key_release,
  output logic                 ghost,
  output logic [COLS+ROWS-1:0] rawcode
);

  localparam int unsigned TMR_W  = $clog2(SETTLE_CYCLES);
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_COUNT + 1);
  localparam int unsigned CIDX_W = $clog2(COLS);
  localparam int unsigned RIDX_W = $clog2(ROWS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t              state_q, state_d;
  logic [ROWS-1:0]     row_s1, row_s2;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [CIDX_W-1:0]   col_idx_q, col_idx_d, col_inc;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [RIDX_W-1:0]   cand_q, cand_d, low_idx;
  logic [KEY_W-1:0]    keycode_d;
  logic                held_d, valid_d, release_d, ghost_d;
  logic [ROWS-1:0]     low;
  logic                sample, one_low, multi_low;

  // Row pattern decode and sample-point detection
  always_comb begin
    low       = ~row_s2;
    sample    = (timer_q == TMR_W'(SETTLE_CYCLES - 1));
    multi_low = ((low & (low - ROWS'(1))) != '0);
    one_low   = (low != '0) && !multi_low;
    low_idx   = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (low[i]) low_idx = RIDX_W'(i);
    end
    col_inc = (col_idx_q == CIDX_W'(COLS - 1)) ? '0 : col_idx_q + CIDX_W'(1);
  end

  // Next-state and output decisions, taken only at the sample point
  always_comb begin
    state_d   = state_q;
    timer_d   = sample ? '0 : timer_q + TMR_W'(1);
    col_idx_d = col_idx_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    keycode_d = keycode;
    held_d    = key_held;
    valid_d   = 1'b0;
    release_d = 1'b0;
    ghost_d   = 1'b0;
    if (sample) begin
      unique case (state_q)
        SCAN: begin
          if (multi_low) begin
            ghost_d   = 1'b1;
            col_idx_d = col_inc;
          end else if (one_low) begin
            cand_d = low_idx;
            if (CNT_W'(1) == CNT_W'(DEBOUNCE_COUNT)) begin
              state_d   = HELD;
              cnt_d     = '0;
              keycode_d = KEY_W'(col_idx_q) * KEY_W'(ROWS) + KEY_W'(low_idx);
              valid_d   = 1'b1;
              held_d    = 1'b1;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            col_idx_d = col_inc;
          end
        end
        DEBOUNCE: begin
          if (one_low && (low_idx == cand_q)) begin
            if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_COUNT)) begin
              state_d   = HELD;
              cnt_d     = '0;
              keycode_d = KEY_W'(col_idx_q) * KEY_W'(ROWS) + KEY_W'(cand_q);
              valid_d   = 1'b1;
              held_d    = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            ghost_d   = multi_low;
            cnt_d     = '0;
            col_idx_d = col_inc;
            state_d   = SCAN;
          end
        end
        HELD: begin
          // Only the candidate row matters; other rows low are ignored here
          if (row_s2[cand_q]) begin
            if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE_COUNT)) begin
              release_d = 1'b1;
              held_d    = 1'b0;
              cnt_d     = '0;
              col_idx_d = col_inc;
              state_d   = SCAN;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // State, synchroniser and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      row_s1      <= '1;
      row_s2      <= '1;
      timer_q     <= '0;
      col_idx_q   <= '0;
      cnt_q       <= '0;
      cand_q      <= '0;
      col         <= ~COLS'(1);
      keycode     <= '0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      key_release <= 1'b0;
      ghost       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_s1      <= row;
      row_s2      <= row_s1;
      timer_q     <= timer_d;
      col_idx_q   <= col_idx_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      col         <= ~(COLS'(1) << col_idx_d);
      keycode     <= keycode_d;
      key_valid   <= valid_d;
      key_held    <= held_d;
      key_release <= release_d;
      ghost       <= ghost_d;
    end
  end

  // Diagnostic view: driven column and the synchronised rows it produced
  assign rawcode = {col, row_s2};

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: simulated key matrix, directed table,
// hand-written corner sequences and randomized key activity checked every
// cycle against a sample-level behavioural model.
module tb_keypad_scan_debounce;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int SETTLE = 4;
  localparam int DEB    = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [ROWS-1:0]   row;
  logic [COLS-1:0]   col;
  logic [3:0]        keycode;
  logic              key_valid, key_held, key_release, ghost;
  logic [COLS+ROWS-1:0] rawcode;

  bit keys [COLS][ROWS];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Behavioural model state
  int         m_col, m_cand, m_streak, m_key;
  bit         m_held, e_valid, e_release, e_ghost, at_sample;
  logic [ROWS-1:0] e_rawrow;

  keypad_scan_debounce dut (
    .clock       (clock),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .keycode     (keycode),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_release (key_release),
    .ghost       (ghost),
    .rawcode     (rawcode)
  );

  always #5 clock = ~clock;

  // Passive matrix: a pressed key pulls its row low while its column is driven
  always_comb begin
    row = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (col[c] == 1'b0 && keys[c][r]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_keys();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++) keys[c][r] = 1'b0;
  endtask

  task automatic model_reset();
    m_col = 0; m_cand = -1; m_streak = 0; m_key = 0; m_held = 0;
    e_valid = 0; e_release = 0; e_ghost = 0; at_sample = 0; e_rawrow = '1;
  endtask

  task automatic advance();
    m_col = (m_col + 1) % COLS;
  endtask

  task automatic accept(input int r);
    m_key = m_col * ROWS + r; m_held = 1; e_valid = 1; m_streak = 0;
  endtask

  // One scan sample: decide from the keys pressed in the currently driven column
  task automatic model_sample();
    int lows[$];
    for (int r = 0; r < ROWS; r++) begin
      e_rawrow[r] = !keys[m_col][r];
      if (keys[m_col][r]) lows.push_back(r);
    end
    if (m_held) begin
      if (!keys[m_col][m_cand]) m_streak++; else m_streak = 0;
      if (m_streak == DEB) begin
        e_release = 1; m_held = 0; m_cand = -1; m_streak = 0; advance();
      end
    end else if (m_cand < 0) begin
      if (lows.size() == 0) advance();
      else if (lows.size() > 1) begin e_ghost = 1; advance(); end
      else begin
        m_cand = lows[0]; m_streak = 1;
        if (m_streak == DEB) accept(m_cand);
      end
    end else begin
      if (lows.size() == 1 && lows[0] == m_cand) begin
        m_streak++;
        if (m_streak == DEB) accept(m_cand);
      end else begin
        if (lows.size() > 1) e_ghost = 1;
        m_cand = -1; m_streak = 0; advance();
      end
    end
  endtask

  task automatic compare_all();
    logic [COLS-1:0] ecol;
    ecol = ~(COLS'(1) << m_col);
    check("col", col, ecol);
    check("keycode", keycode, m_key);
    check("key_held", key_held, m_held);
    check("key_valid", key_valid, e_valid);
    check("key_release", key_release, e_release);
    check("ghost", ghost, e_ghost);
    check("rawcode_col", rawcode[COLS+ROWS-1:ROWS], ecol);
    if (at_sample) check("rawcode_row", rawcode[ROWS-1:0], e_rawrow);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    e_valid = 0; e_release = 0; e_ghost = 0;
    at_sample = (cyc % SETTLE == 0);
    if (at_sample) model_sample();
    compare_all();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_col"}, col, 4'b1110);
    check({tag, "_keycode"}, keycode, 0);
    check({tag, "_valid"}, key_valid, 0);
    check({tag, "_held"}, key_held, 0);
    check({tag, "_release"}, key_release, 0);
    check({tag, "_ghost"}, ghost, 0);
    check({tag, "_rawcode"}, rawcode, 8'b1110_1111);
  endtask

  typedef struct {
    int k0c, k0r, k1c, k1r, nsamp;
    logic [3:0] ecol;
    int ekey;
    bit eheld;
    int nv, nr, ng;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int cv, cr, cg, first;
    logic [3:0] exp_col;

    tbl[0] = '{2, 1, -1, -1, 4, 4'b1011, 9, 1'b1, 1, 0, 0}; // stable press
    tbl[1] = '{2, 1, -1, -1, 3, 4'b1011, 9, 1'b1, 0, 0, 0}; // still held
    tbl[2] = '{-1, -1, -1, -1, 3, 4'b0111, 9, 1'b0, 0, 1, 0}; // release
    tbl[3] = '{1, 0, 1, 2, 3, 4'b1011, 9, 1'b0, 0, 0, 1}; // two rows on col 1
    tbl[4] = '{-1, -1, -1, -1, 2, 4'b1110, 9, 1'b0, 0, 0, 0}; // idle, wraps
    tbl[5] = '{0, 3, -1, -1, 3, 4'b1110, 3, 1'b1, 1, 0, 0}; // press col 0
    tbl[6] = '{-1, -1, -1, -1, 3, 4'b1101, 3, 1'b0, 0, 1, 0}; // release
    tbl[7] = '{1, 3, -1, -1, 3, 4'b1101, 7, 1'b1, 1, 0, 0}; // press col 1
    tbl[8] = '{1, 3, 1, 1, 2, 4'b1101, 7, 1'b1, 0, 0, 0}; // extra row in held
    tbl[9] = '{1, 1, -1, -1, 3, 4'b1011, 7, 1'b0, 0, 1, 0}; // release w/ other row

    clear_keys();
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals("reset");
    @(negedge clock);
    reset = 1'b0;
    cyc = 0;

    // No keys: each column held exactly SETTLE cycles
    repeat (20) begin
      tick();
      exp_col = ~(4'b0001 << ((cyc / SETTLE) % COLS));
      check("sweep_col", col, exp_col);
      check("sweep_quiet", {key_valid, key_release, ghost}, 3'b000);
    end

    // Directed table
    for (int i = 0; i < 10; i++) begin
      clear_keys();
      if (tbl[i].k0c >= 0) keys[tbl[i].k0c][tbl[i].k0r] = 1'b1;
      if (tbl[i].k1c >= 0) keys[tbl[i].k1c][tbl[i].k1r] = 1'b1;
      cv = 0; cr = 0; cg = 0;
      repeat (tbl[i].nsamp * SETTLE) begin
        tick();
        cv += int'(key_valid); cr += int'(key_release); cg += int'(ghost);
      end
      check($sformatf("tbl%0d_col", i), col, tbl[i].ecol);
      check($sformatf("tbl%0d_keycode", i), keycode, tbl[i].ekey);
      check($sformatf("tbl%0d_held", i), key_held, tbl[i].eheld);
      check($sformatf("tbl%0d_nvalid", i), cv, tbl[i].nv);
      check($sformatf("tbl%0d_nrelease", i), cr, tbl[i].nr);
      check($sformatf("tbl%0d_nghost", i), cg, tbl[i].ng);
    end

    // Bouncing press on col 2: two matching samples then row high
    clear_keys();
    keys[2][1] = 1'b1;
    cv = 0;
    repeat (2 * SETTLE) begin tick(); cv += int'(key_valid); end
    clear_keys();
    repeat (SETTLE) begin tick(); cv += int'(key_valid); end
    check("bounce_nvalid", cv, 0);
    check("bounce_col", col, 4'b0111);
    check("bounce_keycode", keycode, 7);

    // Press latency on col 3: detection sample is cycle 151, strobe at 160
    keys[3][2] = 1'b1;
    first = -1;
    repeat (3 * SETTLE) begin
      tick();
      if (key_valid && first < 0) first = cyc;
    end
    check("press_latency", first, 160);
    check("press_keycode", keycode, 14);
    // Release latency: first high sample is cycle 163, strobe at 172; col wraps
    clear_keys();
    first = -1;
    repeat (3 * SETTLE) begin
      tick();
      if (key_release && first < 0) first = cyc;
    end
    check("release_latency", first, 172);
    check("release_col_wrap", col, 4'b1110);
    check("release_keycode", keycode, 14);

    // Reset asserted mid-HELD
    keys[0][0] = 1'b1;
    repeat (3 * SETTLE) tick();
    check("pre_reset_held", key_held, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async");
    clear_keys();
    @(posedge clock);
    @(posedge clock);
    #1;
    check_reset_vals("in_reset");
    @(negedge clock);
    reset = 1'b0;
    cyc = 0;
    model_reset();

    // Randomized key activity, windows aligned to sample boundaries
    repeat (150) begin
      int sel;
      clear_keys();
      sel = $urandom_range(0, 99);
      if (sel >= 40) keys[$urandom_range(0, COLS - 1)][$urandom_range(0, ROWS - 1)] = 1'b1;
      if (sel >= 85) keys[$urandom_range(0, COLS - 1)][$urandom_range(0, ROWS - 1)] = 1'b1;
      repeat ($urandom_range(1, 8) * SETTLE) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan_debounce.md
# keypad_scan_debounce

Parametrised matrix-keypad scanner with integrated timer-based debounce, one-cycle press/release strobes and multi-key rejection. It drives active-low columns, samples active-low rows (pulled up), and presents a stable key index to the calculator input logic. Generalised to any ROWS x COLS matrix, it replaces the fixed 4x4 free-running scanner.

## Interface
- ROWS, 4, number of row inputs (>=2)
- COLS, 4, number of column outputs (>=2)
- SETTLE_CYCLES, 4, clock cycles each column is driven before rows are sampled (>=3)
- DEBOUNCE_COUNT, 3, consecutive matching samples required to accept a press or release (>=1)
- Derived: KEY_W = $clog2(ROWS*COLS)
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- row  in  ROWS  raw row lines, active-low, asynchronous to clock
- col  out  COLS  column drive, exactly one bit low at all times
- keycode  out  KEY_W  index of last accepted key = col_idx*ROWS + row_idx
- key_valid  out  1  one-cycle strobe when a debounced press is accepted
- key_held  out  1  high from key_valid until the release is accepted
- key_release  out  1  one-cycle strobe when a debounced release is accepted
- ghost  out  1  one-cycle strobe when a sample shows more than one row low
- rawcode  out  COLS+ROWS  {col, synchronised row}, diagnostic

## Operation
- row passes a 2-flop synchroniser; all decisions use the synchronised value.
- Sample timer counts 0..SETTLE_CYCLES-1 and restarts on every column change and state change; a "sample" occurs at terminal count.
- States: SCAN, DEBOUNCE, HELD.
- SCAN: at sample, all rows high -> advance column (COLS-1 wraps to 0). Exactly one row low -> latch candidate {col_idx,row_idx}, match count = 1, go DEBOUNCE, column held. More than one row low -> ghost strobe, advance column, stay SCAN.
- DEBOUNCE: column held. At sample, only candidate row low -> count+1; on reaching DEBOUNCE_COUNT, load keycode, pulse key_valid, set key_held, go HELD. Any other pattern (incl. multi-row, which also pulses ghost) -> clear count, advance column, go SCAN. DEBOUNCE_COUNT=1 accepts directly from SCAN.
- HELD: column held. At sample, candidate row high -> release count+1, else release count cleared (extra rows low in HELD are ignored, no ghost). On reaching DEBOUNCE_COUNT: pulse key_release, clear key_held, advance column, go SCAN.
- keycode holds its value until the next accepted press; never changes on release.
- At most one of key_valid / key_release / ghost is high in any cycle.

## Timing
- Reset values: col = all ones except bit 0 low; keycode 0; key_valid, key_held, key_release, ghost 0; state SCAN; timer and counts 0; synchroniser all ones; rawcode = {col reset value, all ones}.
- Reset asserted mid-DEBOUNCE or mid-HELD returns all outputs to reset values immediately; no release strobe is generated.
- Column dwell in SCAN: exactly SETTLE_CYCLES cycles per column; full no-key sweep = COLS*SETTLE_CYCLES cycles.
- All outputs registered; strobes assert the cycle after the deciding sample.
- Press latency: key_valid asserts 1 + (DEBOUNCE_COUNT-1)*SETTLE_CYCLES cycles after the detecting sample; key_held rises in the same cycle.
- Release latency: key_release asserts 1 + (DEBOUNCE_COUNT-1)*SETTLE_CYCLES cycles after the first sample showing the row high.
- Row edges within 2 cycles of a sample may fall either side; the bench must keep stimulus edges clear of sample points.

## Test plan
- Reset (defaults: 4x4, SETTLE 4, DEBOUNCE 3): col=4'b1110, keycode=0, all strobes and key_held 0; assert reset mid-HELD -> same values asynchronously.
- No keys: col steps 1110,1101,1011,0111,1110, each held exactly 4 cycles; no strobes.
- Stable press col 2 row 1: column freezes at 1011, key_valid single pulse 9 cycles after detection sample, keycode=9, key_held=1.
- Bouncing press: row low for 2 samples then high -> no key_valid, column advances to 0111, scanning resumes.
- Release after case 3: rows high for 3 samples -> key_release single pulse, key_held=0, keycode stays 9, col=0111 next.
- Rows 0 and 2 low on col 1 -> ghost single pulse, no key_valid, col advances to 1011.
